// File: rtl/key_sel_ctrl.sv
// Wave-select key front end: synchronises and debounces the active-low key,
// advances the waveform index on a short press and returns it to 0 on a long
// press. All outputs are registered.
module key_sel_ctrl #(
   parameter int unsigned DEB_CYCLES  = 8,
   parameter int unsigned LONG_CYCLES = 1024,
   parameter int unsigned NUM_WAVES   = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       iclk,
   input  logic       irstn,
   input  logic       ikey_sel_n,
   output logic [1:0] owave_sel,
   output logic       osel_vld,
   output logic       okey_dbn,
   output logic       olong
);

   typedef enum logic [1:0] {
      StIdle,
      StPressDeb,
      StPressed,
      StRelDeb
   } state_e;

   localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
   localparam logic [1:0]       LastWave = 2'(NUM_WAVES - 1);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

   logic             sync1_q, sync2_q;
   logic             key_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [1:0]       wave_q, wave_d;
   logic             vld_q, vld_d;
   logic             dbn_q, dbn_d;
   logic             long_q, long_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CntOne;
   endfunction

   // Two-flop synchroniser for the asynchronous key pin, idles released (1).
   always_ff @(posedge iclk) begin
      if (!irstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= ikey_sel_n;
         sync2_q <= sync1_q;
      end
   end

   assign key_s = sync2_q;

   // Next-state logic: debounce FSM, hold timer and waveform index update.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
      wave_d  = wave_q;
      vld_d   = 1'b0;
      long_d  = long_q;
      case (state_q)
         StIdle: begin
            if (!key_s) begin
               state_d = StPressDeb;
               dcnt_d  = CntOne;
            end else begin
               dcnt_d = '0;
            end
         end
         StPressDeb: begin
            if (key_s) begin
               // Glitch: back to idle with no output effect.
               state_d = StIdle;
               dcnt_d  = '0;
            end else if (dcnt_q == DebLast) begin
               state_d = StPressed;
               wave_d  = (wave_q == LastWave) ? 2'd0 : wave_q + 2'd1;
               vld_d   = 1'b1;
               hcnt_d  = '0;
               dcnt_d  = '0;
            end else begin
               dcnt_d = sat_inc(dcnt_q);
            end
         end
         StPressed: begin
            if (key_s) begin
               state_d = StRelDeb;
               dcnt_d  = CntOne;
            end else begin
               hcnt_d = sat_inc(hcnt_q);
               // Long press fires once; strobe even if the index is already 0.
               if ((hcnt_d >= LongLast) && !long_q) begin
                  long_d = 1'b1;
                  wave_d = 2'd0;
                  vld_d  = 1'b1;
               end
            end
         end
         StRelDeb: begin
            if (!key_s) begin
               // Release bounce: hold timer keeps its value.
               state_d = StPressed;
               dcnt_d  = '0;
            end else if (dcnt_q == DebLast) begin
               state_d = StIdle;
               long_d  = 1'b0;
               hcnt_d  = '0;
               dcnt_d  = '0;
            end else begin
               dcnt_d = sat_inc(dcnt_q);
            end
         end
         default: begin
            state_d = StIdle;
            dcnt_d  = '0;
            hcnt_d  = '0;
         end
      endcase
      dbn_d = (state_d == StIdle) || (state_d == StPressDeb);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge iclk) begin
      if (!irstn) begin
         state_q <= StIdle;
         dcnt_q  <= '0;
         hcnt_q  <= '0;
         wave_q  <= 2'd0;
         vld_q   <= 1'b0;
         dbn_q   <= 1'b1;
         long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         hcnt_q  <= hcnt_d;
         wave_q  <= wave_d;
         vld_q   <= vld_d;
         dbn_q   <= dbn_d;
         long_q  <= long_d;
      end
   end

   assign owave_sel = wave_q;
   assign osel_vld  = vld_q;
   assign okey_dbn  = dbn_q;
   assign olong     = long_q;

endmodule

// File: tb/tb_key_sel_ctrl.sv
// Self-checking bench for key_sel_ctrl: behavioural run-length model checked
// every cycle, a vector table of press lengths, and hand-written sequences.
module tb_key_sel_ctrl;

   localparam int unsigned DEB  = 8;
   localparam int unsigned LONG = 1024;
   localparam int unsigned NW   = 4;
   localparam int unsigned CW   = 16;

   logic       clk;
   logic       rstn;
   logic       key_n;
   logic [1:0] owave_sel;
   logic       osel_vld;
   logic       okey_dbn;
   logic       olong;

   key_sel_ctrl #(
      .DEB_CYCLES (DEB),
      .LONG_CYCLES(LONG),
      .NUM_WAVES  (NW),
      .CNT_W      (CW)
   ) u_dut (
      .iclk      (clk),
      .irstn     (rstn),
      .ikey_sel_n(key_n),
      .owave_sel (owave_sel),
      .osel_vld  (osel_vld),
      .okey_dbn  (okey_dbn),
      .olong     (olong)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   strobes[$];
   int   waves[$];
   logic prev_vld     = 1'b0;
   logic dbn_low_seen = 1'b0;

   // Reference model: key level flips after DEB consecutive opposite samples;
   // hold time counts low samples that follow a low sample while pressed.
   logic m_s1 = 1'b1, m_s2 = 1'b1;
   logic m_level = 1'b1, m_prev = 1'b1, m_vld = 1'b0, m_long = 1'b0;
   int   m_run = 0, m_hold = 0, m_wave = 0;

   task automatic model_step(input logic pin, input logic rst_n);
      logic ks;
      logic was_low;
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_prev = 1'b1;
         m_vld = 1'b0; m_long = 1'b0; m_run = 0; m_hold = 0; m_wave = 0;
         return;
      end
      ks      = m_s2;
      m_s2    = m_s1;
      m_s1    = pin;
      was_low = !m_prev;
      m_run   = (ks == m_prev) ? m_run + 1 : 1;
      m_prev  = ks;
      m_vld   = 1'b0;
      if ((ks != m_level) && (m_run >= int'(DEB))) begin
         m_level = ks;
         if (!ks) begin
            m_wave = (m_wave + 1) % int'(NW);
            m_vld  = 1'b1;
            m_hold = 0;
         end else begin
            m_long = 1'b0;
            m_hold = 0;
         end
      end else if (!m_level && !ks && was_low) begin
         m_hold++;
         if ((m_hold == int'(LONG) - 1) && !m_long) begin
            m_long = 1'b1;
            m_wave = 0;
            m_vld  = 1'b1;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic tick(input logic pin, input logic rst_n);
      logic [4:0] exp_v;
      logic [4:0] act_v;
      key_n = pin;
      rstn  = rst_n;
      @(posedge clk);
      model_step(pin, rst_n);
      @(negedge clk);
      cyc++;
      exp_v = {2'(m_wave), m_vld, m_level, m_long};
      act_v = {owave_sel, osel_vld, okey_dbn, olong};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL model: got wave/vld/dbn/long=%b expected %b (cycle %0d)",
                  act_v, exp_v, cyc);
      end
      checks++;
      if (osel_vld && prev_vld) begin
         errors++;
         $display("FAIL strobe_gap: got consecutive strobes expected none (cycle %0d)", cyc);
      end
      prev_vld = osel_vld;
      if (osel_vld === 1'b1) begin
         strobes.push_back(cyc);
         waves.push_back(int'(owave_sel));
      end
      if (okey_dbn === 1'b0) dbn_low_seen = 1'b1;
   endtask

   task automatic run(input logic pin, input int n);
      for (int i = 0; i < n; i++) tick(pin, 1'b1);
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
   endtask

   typedef struct {
      int low_len;
      int exp_strobes;
      int exp_wave;
      int exp_dbn_low;
   } vec_t;

   vec_t vecs[8];
   int   exp_seq[5];
   int   c0;
   int   n;
   logic lvl;

   initial begin
      vecs[0] = '{1,  0, 0, 0};
      vecs[1] = '{4,  0, 0, 0};
      vecs[2] = '{7,  0, 0, 0};
      vecs[3] = '{8,  1, 1, 1};
      vecs[4] = '{10, 1, 2, 1};
      vecs[5] = '{9,  1, 3, 1};
      vecs[6] = '{10, 1, 0, 1};
      vecs[7] = '{7,  0, 0, 0};
      exp_seq = '{1, 2, 3, 0, 1};

      rstn  = 1'b0;
      key_n = 1'b0;
      @(negedge clk);

      // Reset held with key pressed, then fresh debounce after release.
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("rst_wave", int'(owave_sel), 0);
      chk("rst_vld", int'(osel_vld), 0);
      chk("rst_dbn", int'(okey_dbn), 1);
      chk("rst_long", int'(olong), 0);
      strobes.delete(); waves.delete();
      c0 = cyc;
      run(1'b0, 20);
      run(1'b1, 30);
      chk("rst_strobe_count", strobes.size(), 1);
      if (strobes.size() >= 1) chk("rst_strobe_edge", strobes[0] - c0, int'(DEB) + 2);
      chk("rst_wave_after", int'(owave_sel), 1);

      // Short presses: 10 low every 2048 cycles.
      do_reset();
      for (int p = 0; p < 5; p++) begin
         strobes.delete(); waves.delete();
         c0 = cyc;
         run(1'b0, 10);
         run(1'b1, 2038);
         chk($sformatf("short%0d_count", p), strobes.size(), 1);
         if (strobes.size() >= 1)
            chk($sformatf("short%0d_edge", p), strobes[0] - c0, int'(DEB) + 2);
         chk($sformatf("short%0d_wave", p), int'(owave_sel), exp_seq[p]);
      end

      // Table of press lengths, including glitches and the DEB boundary.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         strobes.delete(); waves.delete();
         dbn_low_seen = 1'b0;
         run(1'b0, vecs[i].low_len);
         run(1'b1, 30);
         chk($sformatf("vec%0d_strobes", i), strobes.size(), vecs[i].exp_strobes);
         chk($sformatf("vec%0d_wave", i), int'(owave_sel), vecs[i].exp_wave);
         chk($sformatf("vec%0d_dbn_low", i), int'(dbn_low_seen), vecs[i].exp_dbn_low);
      end

      // Bouncing release.
      do_reset();
      run(1'b0, 20);
      strobes.delete(); waves.delete();
      run(1'b1, 3);
      run(1'b0, 2);
      chk("bounce_dbn_held", int'(okey_dbn), 0);
      c0 = cyc;
      n  = -1;
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, 1'b1);
         if ((n < 0) && (okey_dbn === 1'b1)) n = cyc - c0;
      end
      chk("bounce_dbn_edge", n, int'(DEB) + 2);
      chk("bounce_no_strobe", strobes.size(), 0);
      chk("bounce_wave", int'(owave_sel), 1);

      // Long press from wave 2.
      do_reset();
      run(1'b0, 10); run(1'b1, 30);
      run(1'b0, 10); run(1'b1, 30);
      chk("long_pre_wave", int'(owave_sel), 2);
      strobes.delete(); waves.delete();
      run(1'b0, 2000);
      chk("long_strobe_count", strobes.size(), 2);
      if (strobes.size() >= 2) begin
         chk("long_gap", strobes[1] - strobes[0], int'(LONG) - 1);
         chk("long_wave_first", waves[0], 3);
         chk("long_wave_second", waves[1], 0);
      end
      chk("long_flag_held", int'(olong), 1);
      run(1'b1, 30);
      chk("long_flag_cleared", int'(olong), 0);
      chk("long_no_more", strobes.size(), 2);
      chk("long_wave_end", int'(owave_sel), 0);

      // Reset in the middle of a held press.
      do_reset();
      run(1'b0, 10);
      run(1'b0, 500);
      tick(1'b0, 1'b0);
      chk("midrst_wave", int'(owave_sel), 0);
      chk("midrst_vld", int'(osel_vld), 0);
      chk("midrst_dbn", int'(okey_dbn), 1);
      chk("midrst_long", int'(olong), 0);
      strobes.delete(); waves.delete();
      c0 = cyc;
      run(1'b0, 30);
      chk("midrst_strobe_count", strobes.size(), 1);
      if (strobes.size() >= 1) chk("midrst_strobe_edge", strobes[0] - c0, int'(DEB) + 2);
      chk("midrst_wave_after", int'(owave_sel), 1);
      run(1'b1, 30);

      // Randomised key activity against the model.
      do_reset();
      lvl = 1'b1;
      for (int s = 0; s < 60; s++) begin
         int r;
         int len;
         r = int'($urandom_range(0, 9));
         if (r < 5)      len = int'($urandom_range(1, 12));
         else if (r < 8) len = int'($urandom_range(13, 200));
         else            len = int'($urandom_range(900, 1300));
         lvl = ~lvl;
         run(lvl, len);
         if ($urandom_range(0, 39) == 0) tick(lvl, 1'b0);
      end
      run(1'b1, 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_sel_ctrl.md
# key_sel_ctrl

Front-end control stage for the DDS path. It synchronises and debounces the active-low wave-select key and tracks short and long presses. It maintains the current waveform index and drives it, with a one-cycle change strobe, into the DDS waveform lookup that feeds the DAC. Short press advances the waveform; long press returns to waveform 0.

## Interface
Parameters:
- DEB_CYCLES, 8: consecutive stable synchronised samples needed to accept a press or release. Must be ≥ 2. Simulation value; set per board clock.
- LONG_CYCLES, 1024: cycles held after press acceptance that make a long press. Must be > DEB_CYCLES.
- NUM_WAVES, 4: number of waveforms, 2..4.
- CNT_W, 16: width of the debounce and hold counters. DEB_CYCLES and LONG_CYCLES must each be < 2^CNT_W.

Ports:
- iclk, input, 1: system clock (PLL output). One clock domain.
- irstn, input, 1: reset, synchronous, active-low.
- ikey_sel_n, input, 1: raw key, asynchronous, 0 = pressed.
- owave_sel, output, 2: current waveform index, 0..NUM_WAVES-1.
- osel_vld, output, 1: one-cycle strobe, asserted in the cycle owave_sel takes a new value.
- okey_dbn, output, 1: debounced key level, 0 = pressed.
- olong, output, 1: high while the current press has been qualified as long.

## Operation
- **Synchroniser:** two flops, both reset to 1. Output key_s.
- **Registers:** debounce counter dcnt and hold counter hcnt, both CNT_W bits, saturating, never wrapping.
- **FSM states:** IDLE, PRESS_DEB, PRESSED, REL_DEB. Reset state is IDLE.
- **IDLE:**
  - key_s=0 → PRESS_DEB, dcnt=1.
  - Otherwise stay, dcnt=0.
- **PRESS_DEB:**
  - key_s=1 → IDLE, dcnt=0. This is a glitch; there is no output effect.
  - key_s=0 and dcnt==DEB_CYCLES-1 → PRESSED. Same edge: owave_sel advances, osel_vld=1, hcnt=0, dcnt=0.
  - key_s=0 otherwise → dcnt+1.
- **Advance rule:** owave_sel = (owave_sel==NUM_WAVES-1) ? 0 : owave_sel+1.
- **PRESSED:**
  - key_s=1 → REL_DEB, dcnt=1.
  - Otherwise hcnt+1, saturating.
  - When hcnt reaches LONG_CYCLES-1 and olong=0: set olong=1, force owave_sel=0, and pulse osel_vld. This fires at most once per press.
  - The strobe pulses even if owave_sel was already 0.
- **REL_DEB:**
  - key_s=0 → PRESSED, dcnt=0. hcnt is held, not reset, so a bounce during release does not restart long-press timing.
  - key_s=1 and dcnt==DEB_CYCLES-1 → IDLE. Same edge: olong=0, hcnt=0, dcnt=0.
  - key_s=1 otherwise → dcnt+1.
- **okey_dbn:** 1 in IDLE and PRESS_DEB, 0 in PRESSED and REL_DEB. Registered together with the state.
- **Release:** a key release never changes owave_sel.

## Timing
- **Reset values:** state=IDLE, owave_sel=0, osel_vld=0, okey_dbn=1, olong=0, counters=0, sync flops=1.
- **Reset priority:** irstn=0 sampled on any edge forces all reset values, mid-press included.
  - No osel_vld is issued on reset.
  - After reset, a key already held low must still be debounced as a fresh press.
- **Press latency:**
  - ikey_sel_n sampled low at edge k → key_s low after edge k+1.
  - The FSM's first low sample is edge k+2.
  - owave_sel/osel_vld update at edge k+1+DEB_CYCLES, provided the key stays low throughout.
- **Rejected press:** a low pulse shorter than DEB_CYCLES samples produces no strobe.
- **Long-press latency:** osel_vld for the long press occurs LONG_CYCLES-1 edges after the short-press strobe.
  - Requires key_s to stay 0, or to bounce for less than DEB_CYCLES.
- **Strobe rules:**
  - osel_vld never asserts on two consecutive cycles.
  - Short-press and long-press strobes of the same press are at least LONG_CYCLES-1 cycles apart.
- **Outputs:** all registered; no combinational path from ikey_sel_n.

## Test plan
- **Reset:** hold irstn=0 for 3 edges with ikey_sel_n=0 → owave_sel=0, osel_vld=0, okey_dbn=1, olong=0. After release, the first strobe appears at edge 2+DEB_CYCLES relative to the first sample after reset.
- **Short press:** DEB_CYCLES=8; drive ikey_sel_n low 10 cycles every 2048 cycles, 5 presses → owave_sel sequence 1,2,3,0,1. Exactly one osel_vld per press, each at edge k+9.
- **Glitch rejection:** low pulses of 1, 4 and 7 cycles → no osel_vld, owave_sel unchanged, okey_dbn stays 1.
- **Bouncing release:** press accepted; key returns high for 3 cycles, low for 2, then high for good → no extra strobe. okey_dbn returns to 1 DEB_CYCLES+1 edges after the final high edge on the pin.
- **Long press:** owave_sel=2; hold key low 2000 cycles → strobe to 3, then LONG_CYCLES-1 edges later a strobe to 0 with olong=1. No further strobes. olong clears on release acceptance.
- **Reset mid-operation:** irstn pulsed low in PRESSED with hcnt=500 → all reset values. The key held low afterwards produces a fresh short-press strobe to owave_sel=1 after debounce.
